// File: rtl/datain_edge_fifo_if.sv
// Avalon-MM slave bus for datain_edge_fifo: register select, strobes and data,
// with registered read data returned one cycle after the read.
interface datain_edge_fifo_if #(
  parameter int WIDTH = 16
);
  logic [2:0]       address;
  logic             chipselect;
  logic             read;
  logic             write;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/datain_edge_fifo.sv
// Synchronised PIO input with per-bit edge capture, maskable level IRQ and a
// snapshot FIFO that logs every change of the synchronised input value.
module datain_edge_fifo #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  datain_edge_fifo_if.slave avs,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(SYNC_STAGES + 2);
  localparam logic [IW-1:0] INH_DONE = IW'(SYNC_STAGES + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    A_DATA    = 3'd0,
    A_FIFO    = 3'd1,
    A_IRQMASK = 3'd2,
    A_EDGECAP = 3'd3,
    A_STATUS  = 3'd4
  } addr_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] mem    [DEPTH];
  logic [WIDTH-1:0] sval, prev, edgecap, irqmask;
  logic [WIDTH-1:0] rise, fall, chg, evt, w1c;
  logic [WIDTH-1:0] status, rd_mux;
  logic [IW-1:0]    inh_cnt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             det_en, rd_en, wr_en, pop, push, push_ok;

  assign sval   = sync_q[SYNC_STAGES-1];
  assign det_en = (inh_cnt == INH_DONE);
  assign rd_en  = avs.chipselect & avs.read;
  assign wr_en  = avs.chipselect & avs.write;
  assign irq    = |(edgecap & irqmask);

  // Events are masked until the chain and prev hold post-reset samples.
  always_comb begin
    chg  = det_en ? (sval ^ prev) : '0;
    rise = chg & sval;
    fall = chg & prev;
    if (EDGE_TYPE == 0)
      evt = rise;
    else if (EDGE_TYPE == 1)
      evt = fall;
    else
      evt = chg;
  end

  always_comb begin
    w1c     = (wr_en && avs.address == A_EDGECAP) ? avs.writedata : '0;
    pop     = rd_en && (avs.address == A_FIFO) && (count != '0);
    push    = |chg;
    push_ok = push && ((count != FULL_CNT) || pop);
  end

  always_comb begin
    status           = '0;
    status[CW-1:0]   = count;
    status[WIDTH-1]  = overflow;
    rd_mux           = '0;
    case (avs.address)
      A_DATA:    rd_mux = sval;
      A_FIFO:    rd_mux = (count != '0) ? mem[rd_ptr] : '0;
      A_IRQMASK: rd_mux = irqmask;
      A_EDGECAP: rd_mux = edgecap;
      A_STATUS:  rd_mux = status;
      default:   rd_mux = '0;
    endcase
  end

  // Storage has no reset: stale entries are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    if (reset_n && push_ok)
      mem[wr_ptr] <= sval;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      prev         <= '0;
      inh_cnt      <= '0;
      edgecap      <= '0;
      irqmask      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      avs.readdata <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      prev <= sval;
      if (!det_en)
        inh_cnt <= inh_cnt + IW'(1);

      edgecap <= (edgecap & ~w1c) | evt;
      if (wr_en && avs.address == A_IRQMASK)
        irqmask <= avs.writedata;

      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // A dropped push in the same cycle as a clearing write leaves overflow set.
      if (push && !push_ok)
        overflow <= 1'b1;
      else if (wr_en && avs.address == A_STATUS)
        overflow <= 1'b0;

      avs.readdata <= rd_en ? rd_mux : '0;
    end
  end
endmodule

// File: tb/tb_datain_edge_fifo.sv
// Self-checking bench for datain_edge_fifo: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_datain_edge_fifo;
  localparam int W   = 16;
  localparam int D   = 8;
  localparam int SS  = 2;
  localparam int ET  = 0;
  localparam int WM1 = W - 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = '0;
  logic         irq;
  logic         chk_en = 1'b0;

  datain_edge_fifo_if #(.WIDTH(W)) bus ();

  datain_edge_fifo #(
    .WIDTH(W), .DEPTH(D), .SYNC_STAGES(SS), .EDGE_TYPE(ET)
  ) dut (
    .clk(clk), .reset_n(reset_n), .avs(bus), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: the synchroniser is a plain delay line and the FIFO a queue.
  logic [W-1:0]   m_pipe[$];
  logic [W-1:0]   m_fifo[$];
  logic [W-1:0]   m_sval, m_prev, m_ecap, m_mask, m_rd;
  logic [W-1:0]   m_val, m_chg, m_evt;
  logic [WM1-1:0] m_cnt;
  logic           m_ovf, m_irq, m_rden, m_wren, m_pop;
  int             m_age;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_pipe = {};
      for (int i = 0; i < SS; i++) m_pipe.push_back('0);
      m_fifo = {};
      m_sval = '0; m_prev = '0; m_ecap = '0; m_mask = '0; m_rd = '0;
      m_ovf  = 1'b0;
      m_age  = 0;
    end else begin
      m_rden = bus.chipselect && bus.read;
      m_wren = bus.chipselect && bus.write;
      m_cnt  = WM1'(m_fifo.size());
      case (bus.address)
        3'd0:    m_val = m_sval;
        3'd1:    m_val = (m_fifo.size() > 0) ? m_fifo[0] : '0;
        3'd2:    m_val = m_mask;
        3'd3:    m_val = m_ecap;
        3'd4:    m_val = {m_ovf, m_cnt};
        default: m_val = '0;
      endcase
      m_rd  = m_rden ? m_val : '0;
      m_pop = m_rden && bus.address == 3'd1 && m_fifo.size() > 0;

      m_chg = (m_age > SS) ? (m_sval ^ m_prev) : '0;
      m_evt = (ET == 0) ? (m_sval & ~m_prev & m_chg) :
              (ET == 1) ? (~m_sval & m_prev & m_chg) : m_chg;

      if (m_wren && bus.address == 3'd3) m_ecap = m_ecap & ~bus.writedata;
      m_ecap = m_ecap | m_evt;
      if (m_wren && bus.address == 3'd2) m_mask = bus.writedata;
      if (m_wren && bus.address == 3'd4) m_ovf = 1'b0;
      if (m_pop) void'(m_fifo.pop_front());
      if (m_chg != '0) begin
        if (m_fifo.size() < D) m_fifo.push_back(m_sval);
        else m_ovf = 1'b1;
      end

      m_prev = m_sval;
      m_pipe.push_back(in_port);
      void'(m_pipe.pop_front());
      m_sval = m_pipe[0];
      if (m_age < 1000) m_age++;
    end
    m_irq = |(m_ecap & m_mask);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("readdata", bus.readdata, m_rd);
      check("irq", W'(irq), W'(m_irq));
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [W-1:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [W-1:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0; bus.read = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [2:0] a, input logic [W-1:0] exp);
    logic [W-1:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic do_reset(input logic [W-1:0] pins);
    @(negedge clk);
    in_port = pins;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_in(input logic [W-1:0] v);
    @(negedge clk);
    in_port = v;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] d;
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.address = '0; bus.writedata = '0;
    @(posedge clk);
    #1 chk_en = 1'b1;

    // Static-high inputs out of reset raise no event
    in_port = 16'hFFFF;
    repeat (2) @(negedge clk);
    check("rst_readdata", bus.readdata, 16'h0000);
    check("rst_irq", W'(irq), 16'h0000);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    read_expect("t1_data", 3'd0, 16'hFFFF);
    repeat (3) @(negedge clk);
    read_expect("t1_edgecap", 3'd3, 16'h0000);
    read_expect("t1_status", 3'd4, 16'h0000);

    // Rising edge on bit 3 with latency k+2, then W1C clear
    do_reset(16'h0000);
    bus_write(3'd2, 16'h0008);
    repeat (4) @(negedge clk);
    set_in(16'h0008);
    @(negedge clk);
    @(negedge clk);
    check("t2_irq_k1", W'(irq), 16'h0000);
    @(negedge clk);
    check("t2_irq_k2", W'(irq), 16'h0001);
    read_expect("t2_edgecap", 3'd3, 16'h0008);
    bus_write(3'd3, 16'h0008);
    read_expect("t2_edgecap_clr", 3'd3, 16'h0000);
    check("t2_irq_clr", W'(irq), 16'h0000);

    // Three logged changes drained in order, then an empty read
    do_reset(16'h0000);
    repeat (5) @(negedge clk);
    for (int v = 1; v <= 3; v++) begin
      set_in(W'(v));
      repeat (3) @(negedge clk);
    end
    read_expect("t3_count3", 3'd4, 16'h0003);
    read_expect("t3_pop1", 3'd1, 16'h0001);
    read_expect("t3_pop2", 3'd1, 16'h0002);
    read_expect("t3_pop3", 3'd1, 16'h0003);
    read_expect("t3_pop_empty", 3'd1, 16'h0000);
    read_expect("t3_count0", 3'd4, 16'h0000);

    // Ten changes into eight entries: overflow, oldest kept
    do_reset(16'h0000);
    repeat (5) @(negedge clk);
    for (int v = 1; v <= 10; v++) begin
      set_in(W'(v));
      repeat (3) @(negedge clk);
    end
    read_expect("t4_status_ovf", 3'd4, 16'h8008);
    read_expect("t4_oldest", 3'd1, 16'h0001);
    bus_write(3'd4, 16'h0000);
    read_expect("t4_status_clr", 3'd4, 16'h0007);

    // Refill to full, then push and pop land in the same cycle
    set_in(16'h000B);
    repeat (3) @(negedge clk);
    read_expect("t5_full", 3'd4, 16'h0008);
    set_in(16'h000C);
    @(negedge clk);
    read_expect("t5_pop_same", 3'd1, 16'h0002);
    read_expect("t5_status", 3'd4, 16'h0008);
    read_expect("t5_next", 3'd1, 16'h0003);

    // Edge set beats a W1C in the same cycle
    do_reset(16'h0000);
    repeat (5) @(negedge clk);
    set_in(16'h0001);
    @(negedge clk);
    bus_write(3'd3, 16'h0001);
    read_expect("t6_set_wins", 3'd3, 16'h0001);

    // Reset during a read with FIFO entries pending
    set_in(16'h0002);
    repeat (3) @(negedge clk);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 3'd0;
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_rst_readdata", bus.readdata, 16'h0000);
    bus.chipselect = 1'b0; bus.read = 1'b0;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    read_expect("t6_rst_count", 3'd4, 16'h0000);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      case ($urandom_range(7))
        0:       in_port = W'($urandom);
        1, 2:    in_port = in_port ^ W'(1 << $urandom_range(W-1));
        default: ;
      endcase
      bus.chipselect = ($urandom_range(3) != 0);
      bus.read       = ($urandom_range(1) == 0);
      bus.write      = ($urandom_range(3) == 0);
      bus.address    = ($urandom_range(2) == 0) ? 3'd1 : 3'($urandom_range(7));
      bus.writedata  = W'($urandom);
      reset_n        = ($urandom_range(599) != 0);
    end
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
